mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported synchronous memory.
//
// Port 0 (i_*) is a read-only instruction-fetch port. Port 1 (d_*) is a load/store port.
// Each transaction goes IDLE -> ACCESS -> WAIT -> RESP. A misaligned address skips the memory
// and goes straight from IDLE to RESP, returning an error.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   i_req, i_addr               fetch request and byte address
//   i_ack, i_err, i_rdata       fetch completion pulse, error flag and read data
//   d_req, d_we, d_addr,        data request, write enable, byte address,
//   d_wdata, d_wstrb            store data and byte enables
//   d_ack, d_err, d_rdata       data completion pulse, error flag and read data
//   mem_en, mem_we, mem_wstrb,  memory strobe, write enable, byte enables,
//   mem_addr, mem_wdata         word address and write data
//   mem_rdata                   memory read data, valid the cycle after mem_en
//   busy                        high whenever the FSM is not idle
module mem_arbiter #(
    parameter int unsigned DW     = 32,
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [DW-1:0]     i_addr,
    output logic              i_ack,
    output logic              i_err,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic              d_err,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;    // granted port: 0 = fetch, 1 = data
    logic   last_q, last_d;  // port granted by the last completed transaction
    logic   wr_q, wr_d;      // current transaction is a store

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DW-1:0]     i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;

    // Grant candidate: a lone requester wins; on a tie the port not granted last wins.
    logic          sel;
    logic [DW-1:0] sel_addr;
    logic          sel_we;
    logic          misaligned;

    assign sel        = (i_req && d_req) ? ~last_q : d_req;
    assign sel_addr   = sel ? d_addr : i_addr;
    assign sel_we     = sel & d_we;
    assign misaligned = (sel_addr[1:0] != 2'b00);

    // Address bits above the memory window are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sel_addr[DW-1:MEM_AW+2];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wr_d        = wr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wstrb_d = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        i_rdata_d   = '0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        d_rdata_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    gnt_d = sel;
                    wr_d  = sel_we;
                    if (misaligned) begin
                        // Error response without touching memory.
                        state_d = StResp;
                        i_ack_d = ~sel;
                        i_err_d = ~sel;
                        d_ack_d = sel;
                        d_err_d = sel;
                    end else begin
                        state_d     = StAccess;
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_wstrb_d = sel_we ? d_wstrb : 4'b0000;
                        mem_addr_d  = sel_addr[MEM_AW+1:2];
                        mem_wdata_d = sel_we ? d_wdata : '0;
                    end
                end
            end
            StAccess: begin
                state_d = StWait;
            end
            StWait: begin
                // mem_rdata is valid now; latch it straight into the response register.
                state_d = StResp;
                i_ack_d = ~gnt_q;
                d_ack_d = gnt_q;
                if (!wr_q) begin
                    if (gnt_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        i_rdata_d = mem_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
                last_d  = gnt_q;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            wr_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            i_rdata_q   <= i_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model schedules the outputs expected
// on each cycle; one compare process checks every output every cycle. Directed cases pin the
// model with literal values, then randomized traffic runs on both ports.
module tb_mem_arbiter;

    localparam int DW     = 32;
    localparam int MEM_AW = 10;
    localparam int NWORDS = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_req = 1'b0;
    logic [DW-1:0]     i_addr = '0;
    logic              i_ack, i_err;
    logic [DW-1:0]     i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [DW-1:0]     d_addr = '0;
    logic [DW-1:0]     d_wdata = '0;
    logic [3:0]        d_wstrb = '0;
    logic              d_ack, d_err;
    logic [DW-1:0]     d_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_wstrb;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              busy;

    mem_arbiter #(.DW(DW), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 5) return 32'hFFFFFFFF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Environment memory: synchronous, data valid the cycle after mem_en, garbage otherwise.
    logic [31:0] env_mem [NWORDS];
    bit          env_loaded = 1'b0;
    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < NWORDS; i++) env_mem[i] <= init_word(i);
            env_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= merge(env_mem[mem_addr], mem_wdata, mem_wstrb);
            mem_rdata <= mem_we ? $urandom : env_mem[mem_addr];
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Expected outputs per cycle; all-zero is the idle picture.
    typedef struct packed {
        bit        busy, men, mwe;
        bit [3:0]  mstrb;
        bit [9:0]  maddr;
        bit [31:0] mwdata;
        bit        iack, ierr;
        bit [31:0] irdata;
        bit        dack, derr;
        bit [31:0] drdata;
    } exp_t;

    exp_t        sched [64];
    logic [31:0] ref_mem [NWORDS];
    bit          ref_loaded = 1'b0;
    int          cyc = 0;
    int          free_at = 0;
    bit          last_gnt = 1'b1;
    bit          pend_v = 1'b0;
    bit          pend_p = 1'b0;
    int          pend_at = 0;

    // Transaction model: a request seen while free occupies the arbiter for 4 cycles (2 if
    // misaligned); mem_en in the grant cycle, ack two cycles later. The round-robin pointer
    // moves only when a transaction actually completes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!ref_loaded) begin
                for (int i = 0; i < NWORDS; i++) ref_mem[i] <= init_word(i);
                ref_loaded <= 1'b1;
            end
            for (int i = 0; i < 64; i++) sched[i] <= '0;
            last_gnt <= 1'b1;
            free_at  <= 0;
            pend_v   <= 1'b0;
        end else begin : step
            int          n;
            bit          p, we, eff_last;
            logic [31:0] a;
            int          w;
            exp_t        e;
            n = cyc + 1;
            cyc <= n;
            sched[(n + 3) % 64] <= '0;
            eff_last = (pend_v && n >= pend_at) ? pend_p : last_gnt;
            last_gnt <= eff_last;
            if (pend_v && n >= pend_at) pend_v <= 1'b0;
            if (n >= free_at && (i_req || d_req)) begin
                p  = (i_req && d_req) ? !eff_last : d_req;
                a  = p ? d_addr : i_addr;
                we = p && d_we;
                pend_v <= 1'b1;
                pend_p <= p;
                e = '0;
                e.busy = 1'b1;
                if (a[1:0] != 2'b00) begin
                    if (p) begin e.dack = 1'b1; e.derr = 1'b1; end
                    else   begin e.iack = 1'b1; e.ierr = 1'b1; end
                    sched[n % 64] <= e;
                    free_at <= n + 2;
                    pend_at <= n + 1;
                end else begin
                    w = int'(a[11:2]);
                    e.men    = 1'b1;
                    e.mwe    = we;
                    e.mstrb  = we ? d_wstrb : 4'h0;
                    e.maddr  = a[11:2];
                    e.mwdata = we ? d_wdata : 32'h0;
                    sched[n % 64] <= e;
                    e = '0;
                    e.busy = 1'b1;
                    sched[(n + 1) % 64] <= e;
                    if (p) begin e.dack = 1'b1; e.drdata = we ? 32'h0 : ref_mem[w]; end
                    else   begin e.iack = 1'b1; e.irdata = ref_mem[w]; end
                    sched[(n + 2) % 64] <= e;
                    if (we) ref_mem[w] <= merge(ref_mem[w], d_wdata, d_wstrb);
                    free_at <= n + 4;
                    pend_at <= n + 3;
                end
            end
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin : cmp
            exp_t e;
            e = sched[cyc % 64];
            check("busy",      32'(busy),      32'(e.busy));
            check("mem_en",    32'(mem_en),    32'(e.men));
            check("mem_we",    32'(mem_we),    32'(e.mwe));
            check("mem_wstrb", 32'(mem_wstrb), 32'(e.mstrb));
            check("mem_addr",  32'(mem_addr),  32'(e.maddr));
            check("mem_wdata", mem_wdata,      e.mwdata);
            check("i_ack",     32'(i_ack),     32'(e.iack));
            check("i_err",     32'(i_err),     32'(e.ierr));
            check("i_rdata",   i_rdata,        e.irdata);
            check("d_ack",     32'(d_ack),     32'(e.dack));
            check("d_err",     32'(d_err),     32'(e.derr));
            check("d_rdata",   d_rdata,        e.drdata);
        end
    end

    // One request on one port, held until its ack (bounded); lat counts negedges to the ack.
    task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rd, output bit er, output int lat,
                          output bit saw_men, output logic [9:0] maddr, output bit mwe);
        @(negedge clk);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = 0; rd = '0; er = 1'b0; saw_men = 1'b0; maddr = '0; mwe = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_en) begin saw_men = 1'b1; maddr = mem_addr; mwe = mem_we; end
            if (port ? d_ack : i_ack) begin
                lat = k;
                rd  = port ? d_rdata : i_rdata;
                er  = port ? d_err : i_err;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin : main
        logic [31:0] rd;
        bit          er, sm, mw;
        int          lat, acks_in_rst, nacks;
        logic [9:0]  ma;
        int          ack_port [4];
        int          ack_k [4];

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_i_ack", 32'(i_ack), 32'h0);
        check("rst_d_ack", 32'(d_ack), 32'h0);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Fetch of word 4.
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, sm, ma, mw);
        check("fetch_lat", 32'(lat), 32'd3);
        check("fetch_rdata", rd, 32'hDEADBEEF);
        check("fetch_men", 32'(sm), 32'h1);
        check("fetch_maddr", 32'(ma), 32'd4);
        check("fetch_err", 32'(er), 32'h0);

        // Store then load of word 2.
        do_req(1'b1, 1'b1, 32'h8, 32'h0001F000, 4'hF, rd, er, lat, sm, ma, mw);
        check("store_maddr", 32'(ma), 32'd2);
        check("store_mwe", 32'(mw), 32'h1);
        check("store_rdata", rd, 32'h0);
        check("store_lat", 32'(lat), 32'd3);
        do_req(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, sm, ma, mw);
        check("load_rdata", rd, 32'h0001F000);

        // Partial store over all-ones word 5.
        do_req(1'b1, 1'b1, 32'h14, 32'h00001234, 4'h3, rd, er, lat, sm, ma, mw);
        do_req(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat, sm, ma, mw);
        check("partial_rdata", rd, 32'hFFFF1234);

        // Misaligned data access.
        do_req(1'b1, 1'b0, 32'h6, 32'h0, 4'h0, rd, er, lat, sm, ma, mw);
        check("mis_men", 32'(sm), 32'h0);
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(er), 32'h1);
        check("mis_rdata", rd, 32'h0);

        // Asynchronous reset during ACCESS; request stays asserted and is served afterwards.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        @(negedge clk);
        check("ar_men_before", 32'(mem_en), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_busy_after", 32'(busy), 32'h0);
        check("ar_men_after", 32'(mem_en), 32'h0);
        acks_in_rst = 0;
        repeat (2) begin
            @(negedge clk);
            if (d_ack || i_ack) acks_in_rst++;
        end
        check("ar_no_ack", 32'(acks_in_rst), 32'h0);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d_ack) begin lat = k; rd = d_rdata; break; end
        end
        d_req = 1'b0;
        check("ar_restart_lat", 32'(lat), 32'd3);
        check("ar_restart_rdata", rd, 32'hDEADBEEF);

        // Contention: both ports held; grants alternate starting with port 0.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        nacks = 0;
        for (int k = 1; k <= 40 && nacks < 4; k++) begin
            @(negedge clk);
            if (i_ack && nacks < 4) begin ack_port[nacks] = 0; ack_k[nacks] = k; nacks++; end
            if (d_ack && nacks < 4) begin ack_port[nacks] = 1; ack_k[nacks] = k; nacks++; end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("cont_nacks", 32'(nacks), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < nacks) begin
                check($sformatf("cont_port%0d", j), 32'(ack_port[j]), 32'(j % 2));
                check($sformatf("cont_cycle%0d", j), 32'(ack_k[j]), 32'(3 + 4 * j));
            end
        end

        // Randomized traffic on both ports, each holding its request until acked.
        repeat (3) @(negedge clk);
        for (int it = 0; it < 2500; it++) begin
            @(negedge clk);
            if (i_req && i_ack) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = rand_addr();
            end
            if (d_req && d_ack) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = rand_addr();
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
            end
        end
        // Let outstanding requests complete before stopping.
        for (int k = 0; k < 20 && (i_req || d_req); k++) begin
            @(negedge clk);
            if (i_req && i_ack) i_req = 1'b0;
            if (d_req && d_ack) d_req = 1'b0;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
